mp3_track_ctrl: RTL
===================

// Module: mp3_track_ctrl
// PURPOSE
//  Parametrised successor of the two-song player controller. Selects one of NUM_TRACKS
//  tone generators, runs a clean STOPPED/PLAYING/PAUSED FSM and debounces raw buttons.
//  Generates per-track play/restart strobes and gates the selected tone onto the buzzer.
//  Sits between the board buttons and the per-song sequencer instances.
// PARAMETERS
//  NUM_TRACKS       4          number of song sequencers (2..16)
//  TRACK_W          $clog2(NUM_TRACKS)  width of track index (derived, localparam)
//  DEBOUNCE_CYCLES  1_000_000  stable-input cycles before a button edge is accepted (>=2)
// PORTS
//  clock       in   1           system clock; all logic on posedge
//  rst_n       in   1           asynchronous, active-low reset
//  btn_play    in   1           raw play/pause button, active-high
//  btn_stop    in   1           raw stop button
//  btn_next    in   1           raw next-track button
//  btn_prev    in   1           raw previous-track button
//  btn_mute    in   1           raw mute toggle button
//  tone_in     in   NUM_TRACKS  square-wave note output of each sequencer
//  song_end    in   NUM_TRACKS  1-cycle pulse from each sequencer at last note
//  track_sel   out  TRACK_W     currently selected track index
//  track_play  out  NUM_TRACKS  one-hot run enable; bit track_sel high only in PLAYING
//  track_rst   out  NUM_TRACKS  1-cycle restart strobe to a sequencer
//  state       out  2           FSM state (STOPPED=0, PLAYING=1, PAUSED=2)
//  muted       out  1           mute flag
//  buzzer      out  1           registered tone_in[track_sel] & PLAYING & !muted
// BEHAVIOUR
//  - Reset: state=STOPPED, track_sel=0, track_play=0, track_rst=0, muted=0, buzzer=0;
//    debouncer counters cleared. Reset mid-song halts output in the same cycle (async).
//  - Debounce: raw inputs 2-FF synchronised; level accepted after DEBOUNCE_CYCLES stable;
//    accepted rising edge -> 1-cycle pulse. Latency from raw edge: 2+DEBOUNCE_CYCLES+1 clocks.
//  - FSM on pulses, priority stop > play > next > prev in the same cycle (lower dropped):
//    STOPPED --play--> PLAYING (track_rst[sel] pulsed same cycle)
//    PLAYING --play--> PAUSED ; PAUSED --play--> PLAYING (no restart)
//    any --stop--> STOPPED, track_rst[sel] pulsed; stop in STOPPED: no-op, no strobe.
//  - next/prev: track_sel +/-1 modulo NUM_TRACKS (NUM_TRACKS-1 -> 0, 0 -> NUM_TRACKS-1);
//    track_rst[new] pulsed; FSM state unchanged (PLAYING keeps playing new track from start).
//  - mute pulse toggles muted in any state, independent of FSM priority.
//  - song_end[i] for i != track_sel ignored.
//  - buzzer: 1-cycle registered latency from tone_in; forced 0 unless PLAYING and !muted.
//  - All outputs registered; track_rst never has more than one bit set.
// CONFIGURATION
//  AUTO_ADVANCE_EN defined: song_end[track_sel] in PLAYING acts as next (wrap included),
//    ranked below stop/play; restart strobe on new track, stays PLAYING.
//  AUTO_ADVANCE_EN undefined: song_end[track_sel] in PLAYING -> STOPPED, track_sel held,
//    track_rst[sel] pulsed.
// STRUCTURE
//  - Package mp3_pkg: state encoding localparams (ST_STOPPED/ST_PLAYING/ST_PAUSED),
//    button index constants (BTN_PLAY..BTN_MUTE), NUM_BTNS=5.
//  - Sub-module btn_debounce (param DEBOUNCE_CYCLES): sync + counter + edge pulse;
//    instantiated once per button via generate.
//  - Top holds FSM, track index counter, strobe/enable decode, buzzer mux.
// TESTING (sim with NUM_TRACKS=4, DEBOUNCE_CYCLES=4)
//  1. Reset, press play 10 cycles -> state=1, track_play=4'b0001, one track_rst=4'b0001.
//  2. Play twice more -> PAUSED (buzzer=0, track_play=0), then PLAYING with no track_rst.
//  3. In PLAYING press prev at sel=0 -> track_sel=3, track_rst=4'b1000, state stays 1.
//  4. Bounce btn_next 1-0-1 every 2 cycles then hold -> exactly one increment.
//  5. Play+stop accepted same cycle -> state=STOPPED; mute pulse -> buzzer held 0.
//  6. song_end[sel] pulse: with AUTO_ADVANCE_EN sel 1->2 stays PLAYING; without -> STOPPED;
//     song_end on unselected bit -> no change. Assert rst_n low mid-play -> all outputs 0.

Source files
------------

// File: rtl/mp3_track_ctrl_pkg.sv
// Shared constants for the MP3 track controller: FSM state encoding and button indices.
package mp3_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_PLAYING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_t;

  localparam int BTN_PLAY = 0;
  localparam int BTN_STOP = 1;
  localparam int BTN_NEXT = 2;
  localparam int BTN_PREV = 3;
  localparam int BTN_MUTE = 4;
  localparam int NUM_BTNS = 5;

endpackage

// File: rtl/mp3_track_ctrl_if.sv
// Board/sequencer side bundle of the track controller. There is no valid/ready handshake:
// buttons are raw asynchronous levels, song_end is a one-cycle pulse, all outputs are registered levels.
interface mp3_track_ctrl_if #(
  parameter int NUM_TRACKS = 4
);
  localparam int TRACK_W = $clog2(NUM_TRACKS);

  logic                  btn_play;
  logic                  btn_stop;
  logic                  btn_next;
  logic                  btn_prev;
  logic                  btn_mute;
  logic [NUM_TRACKS-1:0] tone_in;
  logic [NUM_TRACKS-1:0] song_end;
  logic [TRACK_W-1:0]    track_sel;
  logic [NUM_TRACKS-1:0] track_play;
  logic [NUM_TRACKS-1:0] track_rst;
  logic [1:0]            state;
  logic                  muted;
  logic                  buzzer;

  modport master (
    output btn_play, btn_stop, btn_next, btn_prev, btn_mute, tone_in, song_end,
    input  track_sel, track_play, track_rst, state, muted, buzzer
  );

  modport slave (
    input  btn_play, btn_stop, btn_next, btn_prev, btn_mute, tone_in, song_end,
    output track_sel, track_play, track_rst, state, muted, buzzer
  );

endinterface

// File: rtl/mp3_track_ctrl_btn_debounce.sv
// One raw button: 2-FF synchroniser, stability counter, and a one-cycle pulse on an accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // cnt is the run length of synchronised samples disagreeing with the accepted level
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        pulse <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mp3_track_ctrl.sv
// Track selector / transport FSM for NUM_TRACKS tone sequencers with debounced buttons and buzzer gate.
// Build option: define AUTO_ADVANCE_EN to advance to the next track on song_end instead of stopping.
module mp3_track_ctrl
  import mp3_pkg::*;
#(
  parameter int NUM_TRACKS      = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input logic            clock,
  input logic            rst_n,
  mp3_track_ctrl_if.slave bus
);
  localparam int TRACK_W = $clog2(NUM_TRACKS);
  localparam logic [TRACK_W-1:0] LAST_TRACK = TRACK_W'(NUM_TRACKS - 1);

  logic [NUM_BTNS-1:0] raw;
  logic [NUM_BTNS-1:0] pulse;

  assign raw[BTN_PLAY] = bus.btn_play;
  assign raw[BTN_STOP] = bus.btn_stop;
  assign raw[BTN_NEXT] = bus.btn_next;
  assign raw[BTN_PREV] = bus.btn_prev;
  assign raw[BTN_MUTE] = bus.btn_mute;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock (clock),
      .rst_n (rst_n),
      .raw   (raw[g]),
      .pulse (pulse[g])
    );
  end

  function automatic logic [NUM_TRACKS-1:0] onehot(input logic [TRACK_W-1:0] idx);
    logic [NUM_TRACKS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  state_t                state_q, state_nxt;
  logic [TRACK_W-1:0]    sel_q, sel_nxt, sel_inc, sel_dec;
  logic                  muted_q, muted_nxt;
  logic [NUM_TRACKS-1:0] rst_q, rst_nxt;
  logic [NUM_TRACKS-1:0] play_q;
  logic                  buzz_q;
  logic                  end_hit;

  assign sel_inc = (sel_q == LAST_TRACK) ? '0 : sel_q + 1'b1;
  assign sel_dec = (sel_q == '0) ? LAST_TRACK : sel_q - 1'b1;
  assign end_hit = (state_q == ST_PLAYING) && bus.song_end[sel_q];

  // One transport action per cycle: stop > play > song end > next > prev; mute is orthogonal
  always_comb begin
    state_nxt = state_q;
    sel_nxt   = sel_q;
    rst_nxt   = '0;
    muted_nxt = muted_q ^ pulse[BTN_MUTE];
    if (pulse[BTN_STOP]) begin
      if (state_q != ST_STOPPED) begin
        state_nxt = ST_STOPPED;
        rst_nxt   = onehot(sel_q);
      end
    end else if (pulse[BTN_PLAY]) begin
      case (state_q)
        ST_STOPPED: begin
          state_nxt = ST_PLAYING;
          rst_nxt   = onehot(sel_q);
        end
        ST_PLAYING: state_nxt = ST_PAUSED;
        ST_PAUSED:  state_nxt = ST_PLAYING;
        default:    state_nxt = ST_STOPPED;
      endcase
    end else if (end_hit) begin
`ifdef AUTO_ADVANCE_EN
      sel_nxt = sel_inc;
      rst_nxt = onehot(sel_inc);
`else
      state_nxt = ST_STOPPED;
      rst_nxt   = onehot(sel_q);
`endif
    end else if (pulse[BTN_NEXT]) begin
      sel_nxt = sel_inc;
      rst_nxt = onehot(sel_inc);
    end else if (pulse[BTN_PREV]) begin
      sel_nxt = sel_dec;
      rst_nxt = onehot(sel_dec);
    end
  end

  // Enables and buzzer are derived from next-state values so they never lag the state output
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STOPPED;
      sel_q   <= '0;
      muted_q <= 1'b0;
      rst_q   <= '0;
      play_q  <= '0;
      buzz_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      sel_q   <= sel_nxt;
      muted_q <= muted_nxt;
      rst_q   <= rst_nxt;
      play_q  <= (state_nxt == ST_PLAYING) ? onehot(sel_nxt) : '0;
      buzz_q  <= bus.tone_in[sel_nxt] & (state_nxt == ST_PLAYING) & ~muted_nxt;
    end
  end

  assign bus.state      = state_q;
  assign bus.track_sel  = sel_q;
  assign bus.muted      = muted_q;
  assign bus.track_rst  = rst_q;
  assign bus.track_play = play_q;
  assign bus.buzzer     = buzz_q;

endmodule
